// File: rtl/nco_note_sequencer.sv
// Note sequencer for the NCO: walks a {fcw, duration} table.
// It drives fcw and a sample-rate next_sample strobe.
module nco_note_sequencer #(
  parameter int CYCLES_PER_SAMPLE = 2500,
  parameter int DEPTH             = 16,
  parameter int FCW_W             = 24,
  parameter int DUR_W             = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [FCW_W-1:0]         wr_fcw,
  input  logic [DUR_W-1:0]         wr_dur,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop_en,
  output logic                     next_sample,
  output logic [FCW_W-1:0]         fcw,
  output logic [$clog2(DEPTH)-1:0] note_idx,
  output logic                     busy,
  output logic                     done
);

  // state | meaning
  // IDLE  | no tone; sample counter held at 0; waiting for start
  // PLAY  | tone playing; strobes every CYCLES_PER_SAMPLE clks; table walk active

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CYCLES_PER_SAMPLE);
  localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES_PER_SAMPLE - 1);
  localparam logic [AW-1:0] IDX_LAST = AW'(DEPTH - 1);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t           state;
  logic [FCW_W-1:0] tab_fcw [DEPTH];
  logic [DUR_W-1:0] tab_dur [DEPTH];
  logic [CW-1:0]    sample_cnt;
  logic [CW-1:0]    cnt_nxt;
  logic [DUR_W-1:0] remaining;
  logic [AW-1:0]    nxt_idx;
  logic             cnt_wrap;
  logic             seq_end;

  // Table is deliberately not reset so a programmed sequence survives rst_n.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tab_fcw[wr_addr] <= wr_fcw;
      tab_dur[wr_addr] <= wr_dur;
    end
  end

  always_comb begin
    cnt_wrap = (sample_cnt == CNT_LAST);
    cnt_nxt  = cnt_wrap ? '0 : sample_cnt + CW'(1);
    nxt_idx  = note_idx + AW'(1);
    seq_end  = (note_idx == IDX_LAST) || (tab_dur[nxt_idx] == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      sample_cnt  <= '0;
      remaining   <= '0;
      fcw         <= '0;
      note_idx    <= '0;
      next_sample <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          sample_cnt  <= '0;
          next_sample <= 1'b0;
          if (start && !stop) begin
            if (tab_dur[0] == '0) begin
              done <= 1'b1;
            end else begin
              state     <= PLAY;
              busy      <= 1'b1;
              note_idx  <= '0;
              fcw       <= tab_fcw[0];
              remaining <= tab_dur[0];
            end
          end
        end

        PLAY: begin
          if (stop) begin
            state       <= IDLE;
            busy        <= 1'b0;
            fcw         <= '0;
            note_idx    <= '0;
            remaining   <= '0;
            sample_cnt  <= '0;
            next_sample <= 1'b0;
            done        <= 1'b1;
          end else begin
            sample_cnt  <= cnt_nxt;
            next_sample <= (cnt_nxt == CNT_LAST);
            // The strobe cycle itself still carries the old fcw; the swap lands one clk later.
            if (cnt_wrap) begin
              if (remaining == DUR_W'(1)) begin
                if (!seq_end) begin
                  note_idx  <= nxt_idx;
                  fcw       <= tab_fcw[nxt_idx];
                  remaining <= tab_dur[nxt_idx];
                end else if (loop_en) begin
                  note_idx  <= '0;
                  fcw       <= tab_fcw[0];
                  remaining <= tab_dur[0];
                end else begin
                  state       <= IDLE;
                  busy        <= 1'b0;
                  fcw         <= '0;
                  note_idx    <= '0;
                  remaining   <= '0;
                  sample_cnt  <= '0;
                  next_sample <= 1'b0;
                  done        <= 1'b1;
                end
              end else begin
                remaining <= remaining - DUR_W'(1);
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nco_note_sequencer.sv
// Scoreboard bench for nco_note_sequencer with CYCLES_PER_SAMPLE=4.
// Stimulus queues timed expected events; a monitor pops them on strobe, done, or output change.
module tb_nco_note_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [23:0] wr_fcw = '0;
  logic [15:0] wr_dur = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop_en = 1'b0;
  logic        next_sample;
  logic [23:0] fcw;
  logic [3:0]  note_idx;
  logic        busy;
  logic        done;

  nco_note_sequencer #(
    .CYCLES_PER_SAMPLE(4),
    .DEPTH(16),
    .FCW_W(24),
    .DUR_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_fcw(wr_fcw),
    .wr_dur(wr_dur), .start(start), .stop(stop), .loop_en(loop_en),
    .next_sample(next_sample), .fcw(fcw), .note_idx(note_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int          t;
    logic        ns;
    logic        dn;
    logic        bz;
    logic [23:0] f;
    logic [3:0]  ix;
  } ev_t;

  ev_t exp_q[$];
  int  n_vec = 0;
  int  n_err = 0;
  bit  mon_en = 1'b0;

  task automatic push(input int t, input logic ns, input logic dn, input logic bz,
                      input logic [23:0] f, input logic [3:0] ix);
    ev_t e;
    e.t = t; e.ns = ns; e.dn = dn; e.bz = bz; e.f = f; e.ix = ix;
    exp_q.push_back(e);
  endtask

  task automatic monitor();
    logic        pb = 1'b0;
    logic [23:0] pf = '0;
    logic [3:0]  pi = '0;
    ev_t         e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (next_sample || done || busy !== pb || fcw !== pf || note_idx !== pi) begin
          n_vec++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event t=%0d ns=%0b dn=%0b bz=%0b fcw=%h idx=%0d",
                     cyc, next_sample, done, busy, fcw, note_idx);
          end else begin
            e = exp_q.pop_front();
            if (e.t != cyc || e.ns !== next_sample || e.dn !== done || e.bz !== busy ||
                e.f !== fcw || e.ix !== note_idx) begin
              n_err++;
              $display("FAIL event got t=%0d ns=%0b dn=%0b bz=%0b fcw=%h idx=%0d expected t=%0d ns=%0b dn=%0b bz=%0b fcw=%h idx=%0d",
                       cyc, next_sample, done, busy, fcw, note_idx, e.t, e.ns, e.dn, e.bz, e.f, e.ix);
            end
          end
        end
        pb = busy; pf = fcw; pi = note_idx;
      end
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [23:0] f, input logic [15:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_fcw = f; wr_dur = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Two-note sequence: entry 0 for 3 samples, entry 1 for 2 samples.
  task automatic expect_two_notes(input int s);
    push(s,      1'b0, 1'b0, 1'b1, 24'h10000, 4'd0);
    push(s + 3,  1'b1, 1'b0, 1'b1, 24'h10000, 4'd0);
    push(s + 7,  1'b1, 1'b0, 1'b1, 24'h10000, 4'd0);
    push(s + 11, 1'b1, 1'b0, 1'b1, 24'h10000, 4'd0);
    push(s + 12, 1'b0, 1'b0, 1'b1, 24'h20000, 4'd1);
    push(s + 15, 1'b1, 1'b0, 1'b1, 24'h20000, 4'd1);
    push(s + 19, 1'b1, 1'b0, 1'b1, 24'h20000, 4'd1);
  endtask

  task automatic load_two_notes();
    wr(4'd0, 24'h10000, 16'd3);
    wr(4'd1, 24'h20000, 16'd2);
    wr(4'd2, 24'hABCDE, 16'd0);
  endtask

  initial begin
    int s;
    fork
      monitor();
    join_none

    // 1: reset, then long idle
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (100) @(negedge clk);
    n_vec++;
    if ({next_sample, fcw, note_idx, busy, done} !== '0) begin
      n_err++;
      $display("FAIL reset_state got ns=%0b fcw=%h idx=%0d bz=%0b dn=%0b expected all 0",
               next_sample, fcw, note_idx, busy, done);
    end

    // 2: two notes, no loop
    load_two_notes();
    loop_en = 1'b0;
    @(negedge clk);
    s = cyc + 1;
    expect_two_notes(s);
    push(s + 20, 1'b0, 1'b1, 1'b0, 24'h0, 4'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until(s + 25);

    // 3: loop; rewriting entry 0 mid-note only shows on the next reload; then stop
    loop_en = 1'b1;
    @(negedge clk);
    s = cyc + 1;
    expect_two_notes(s);
    push(s + 20, 1'b0, 1'b0, 1'b1, 24'h30000, 4'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until(s + 4);
    wr(4'd0, 24'h30000, 16'd3);
    wait_until(s + 21);
    push(s + 22, 1'b0, 1'b1, 1'b0, 24'h0, 4'd0);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    loop_en = 1'b0;
    wait_until(s + 30);

    // 4: empty sequence gives a lone done pulse; start+stop in IDLE does nothing
    wr(4'd0, 24'h12345, 16'd0);
    @(negedge clk);
    s = cyc + 1;
    push(s, 1'b0, 1'b1, 1'b0, 24'h0, 4'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    repeat (12) @(negedge clk);

    // 5: all 16 entries, one sample each; ends at the last table slot
    for (int i = 0; i < 16; i++) wr(4'(i), 24'(i) << 16, 16'd1);
    @(negedge clk);
    s = cyc + 1;
    push(s, 1'b0, 1'b0, 1'b1, 24'h0, 4'd0);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) push(s + 4 * k, 1'b0, 1'b0, 1'b1, 24'(k) << 16, 4'(k));
      push(s + 4 * k + 3, 1'b1, 1'b0, 1'b1, 24'(k) << 16, 4'(k));
    end
    push(s + 64, 1'b0, 1'b1, 1'b0, 24'h0, 4'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until(s + 70);

    // 6: reset mid-note kills playback silently; table survives for a replay
    load_two_notes();
    @(negedge clk);
    s = cyc + 1;
    push(s,     1'b0, 1'b0, 1'b1, 24'h10000, 4'd0);
    push(s + 3, 1'b1, 1'b0, 1'b1, 24'h10000, 4'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until(s + 5);
    push(s + 6, 1'b0, 1'b0, 1'b0, 24'h0, 4'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    s = cyc + 1;
    expect_two_notes(s);
    push(s + 20, 1'b0, 1'b1, 1'b0, 24'h0, 4'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until(s + 25);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    while (exp_q.size() != 0) begin
      ev_t e;
      e = exp_q.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL missing_event got none expected t=%0d ns=%0b dn=%0b bz=%0b fcw=%h idx=%0d",
               e.t, e.ns, e.dn, e.bz, e.f, e.ix);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
